// File: rtl/crono_ctrl.sv
// rtl/crono_ctrl.sv - Stopwatch controller: debounced buttons, RUN/PAUSE/IDLE FSM, prescaled BCD seconds count.
// Optional lap/display-freeze logic is built when CRONO_LAP_EN is defined.
module crono_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DEB_LEN  = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [3:0] units,
  output logic [2:0] tens,
  output logic       running,
  output logic       lap_active,
  output logic       tick,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEB_LEN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  // Button index 0 = start_stop, 1 = clear, 2 = lap (lap build only).
`ifdef CRONO_LAP_EN
  localparam int NB = 3;
  logic [NB-1:0] raw;
  assign raw = {btn_lap, btn_clear, btn_start_stop};
`else
  localparam int NB = 2;
  logic [NB-1:0] raw;
  logic          unused_lap;
  assign raw        = {btn_clear, btn_start_stop};
  assign unused_lap = btn_lap;
`endif

  logic [NB-1:0] s1, s2, deb, press;
  logic [CW-1:0] cnt [NB];

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [3:0]    cnt_u;
  logic [2:0]    cnt_t;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < NB; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_LEN - 1)) begin
          deb[i]   <= s2[i];
          cnt[i]   <= '0;
          press[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Prescaler and count advance on the current state; a same-cycle pause still takes that step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      cnt_u <= 4'd0;
      cnt_t <= 3'd0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (state == RUN) begin
        if (presc == PW'(TICK_DIV - 1)) begin
          presc <= '0;
          tick  <= 1'b1;
          if (cnt_u == 4'd9) begin
            cnt_u <= 4'd0;
            if (cnt_t == 3'd5) begin
              cnt_t <= 3'd0;
              wrap  <= 1'b1;
            end else begin
              cnt_t <= cnt_t + 3'd1;
            end
          end else begin
            cnt_u <= cnt_u + 4'd1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
      if (press[0]) begin
        state <= (state == RUN) ? PAUSE : RUN;
      end else if (press[1] && state == PAUSE) begin
        state <= IDLE;
        presc <= '0;
        cnt_u <= 4'd0;
        cnt_t <= 3'd0;
      end
    end
  end

  assign running = (state == RUN);

`ifdef CRONO_LAP_EN
  logic       lap_q;
  logic [3:0] lap_u;
  logic [2:0] lap_t;

  // A start_stop or clear press in the same cycle swallows the lap press.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q <= 1'b0;
      lap_u <= 4'd0;
      lap_t <= 3'd0;
    end else if (!press[0]) begin
      if (press[1]) begin
        if (state == PAUSE) lap_q <= 1'b0;
      end else if (press[2]) begin
        if (state == RUN) begin
          lap_q <= ~lap_q;
          if (!lap_q) begin
            lap_u <= cnt_u;
            lap_t <= cnt_t;
          end
        end else if (state == PAUSE) begin
          lap_q <= 1'b0;
        end
      end
    end
  end

  assign lap_active = lap_q;
  assign units      = lap_q ? lap_u : cnt_u;
  assign tens       = lap_q ? lap_t : cnt_t;
`else
  assign lap_active = 1'b0;
  assign units      = cnt_u;
  assign tens       = cnt_t;
`endif

endmodule
